// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, widths, instruction field positions and
// the fetch FSM state encoding.
package cpu_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;

  // Opcodes
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_ADDI  = 4'd2;
  localparam logic [3:0] OP_LOAD  = 4'd3;
  localparam logic [3:0] OP_STORE = 4'd4;
  localparam logic [3:0] OP_BEQ   = 4'd5;
  localparam logic [3:0] OP_HALT  = 4'd6;
  localparam logic [3:0] OP_JAL   = 4'd7;

  // Instruction fields: {opcode, rd, rs1, rs2, imm}
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 24;
  localparam int RS1_MSB = 23;
  localparam int RS1_LSB = 20;
  localparam int RS2_MSB = 19;
  localparam int RS2_LSB = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters, only instantiated when FETCH_PERF_EN is defined.
// Both counters wrap at 2^32.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_pulse,
  input  logic        stall_pulse,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  // Count delivered instructions and decode back-pressure cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetch_pulse) perf_fetched <= perf_fetched + 32'd1;
      if (stall_pulse) perf_stall   <= perf_stall + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read per instruction
// (single outstanding request), hands the word to decode via valid/ready,
// follows redirects from execute and stops for good on HALT.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counter outputs.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W        = cpu_pkg::PC_W,
  parameter int              INSTR_W     = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]      HALT_OPCODE = 4'b0110
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_in,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            drop;   // response of the in-flight request is stale

  // Fetch FSM. Priority: halt_in > redirect > normal flow. In HALTED
  // every input except rst is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      if (state != HALTED) begin
        if (halt_in) begin
          state       <= HALTED;
          halted      <= 1'b1;
          instr_valid <= 1'b0;
        end else if (redirect_valid) begin
          pc <= redirect_pc;
          case (state)
            // The request going out now is for the old pc; mark it stale.
            REQ: begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
              drop      <= 1'b1;
              state     <= WAIT;
            end
            WAIT: begin
              if (imem_rvalid) begin
                drop  <= 1'b0;
                state <= REQ;
              end else begin
                drop  <= 1'b1;
              end
            end
            HOLD: begin
              instr_valid <= 1'b0;
              state       <= REQ;
            end
            default: ;
          endcase
        end else begin
          case (state)
            REQ: begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
              state     <= WAIT;
            end
            WAIT: begin
              if (imem_rvalid) begin
                if (drop) begin
                  drop  <= 1'b0;
                  state <= REQ;
                end else begin
                  instr       <= imem_rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  pc          <= pc + PC_W'(1);
                  state       <= HOLD;
                end
              end
            end
            HOLD: begin
              if (instr_ready) begin
                instr_valid <= 1'b0;
                if (instr[OPC_MSB:OPC_LSB] == HALT_OPCODE) begin
                  state  <= HALTED;
                  halted <= 1'b1;
                end else begin
                  state  <= REQ;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_pulse;
  logic stall_pulse;

  // A handshake flushed by redirect or halt in the same cycle is not a delivery
  assign fetch_pulse = (state == HOLD) && instr_valid && instr_ready &&
                       !redirect_valid && !halt_in;
  assign stall_pulse = (state == HOLD) && !instr_ready;

  fetch_perf_counters u_perf (
    .clk          (clk),
    .rst          (rst),
    .fetch_pulse  (fetch_pulse),
    .stall_pulse  (stall_pulse),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule
